// File: rtl/sram_arbiter_pkg.sv
// sram_arbiter_pkg: port encodings and SRAM geometry defaults shared with sram.
package sram_arbiter_pkg;
  localparam int SRAM_DATA_WIDTH = 8;
  localparam int SRAM_ADDR_WIDTH = 11;
  typedef enum logic {PORT0 = 1'b0, PORT1 = 1'b1} port_e;
endpackage

// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: both requester channels plus the SRAM-side bus of the arbiter.
interface sram_arbiter_if import sram_arbiter_pkg::*; #(
  parameter int DW = SRAM_DATA_WIDTH,
  parameter int AW = SRAM_ADDR_WIDTH
);
  logic          req0_valid, req1_valid, req0_ready, req1_ready, req0_we, req1_we;
  logic [AW-1:0] req0_addr, req1_addr, sram_addr;
  logic [DW-1:0] req0_wdata, req1_wdata, rsp0_rdata, rsp1_rdata, sram_wdata, sram_rdata;
  logic          rsp0_valid, rsp1_valid, sram_en, sram_we;
  modport slave (
    input  req0_valid, req1_valid, req0_we, req1_we, req0_addr, req1_addr,
           req0_wdata, req1_wdata, sram_rdata,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_rdata, rsp1_rdata,
           sram_en, sram_we, sram_addr, sram_wdata
  );
  modport master (
    output req0_valid, req1_valid, req0_we, req1_we, req0_addr, req1_addr,
           req0_wdata, req1_wdata, sram_rdata,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_rdata, rsp1_rdata,
           sram_en, sram_we, sram_addr, sram_wdata
  );
endinterface

// File: rtl/sram_arbiter_rr_burst_sel.sv
// rr_burst_sel: two-way round-robin grant select with a bounded burst per owner.
module rr_burst_sel import sram_arbiter_pkg::*; #(
  parameter int MAX_BURST = 4
) (
  input  logic  clk,
  input  logic  reset_n,
  input  logic  valid0,
  input  logic  valid1,
  output logic  gnt,
  output port_e gnt_port
);
  localparam logic [3:0] MB = 4'(MAX_BURST);
  port_e      owner;
  logic [3:0] burst_cnt;
  // Reset gates the grant so it drops asynchronously with the registers.
  always_comb begin
    gnt = reset_n && (valid0 || valid1);
    gnt_port = (valid0 && valid1) ? ((burst_cnt < MB) ? owner : port_e'(~owner))
                                  : (valid1 ? PORT1 : PORT0);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      owner <= PORT1;
      burst_cnt <= MB;
    end else if (gnt) begin
      owner <= gnt_port;
      burst_cnt <= (gnt_port != owner) ? 4'd1 : (burst_cnt == MB) ? MB : burst_cnt + 4'd1;
    end
endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one synchronous-read SRAM between two valid/ready requesters.
module sram_arbiter import sram_arbiter_pkg::*; #(
  parameter int DATA_WIDTH = SRAM_DATA_WIDTH,
  parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH,
  parameter int MAX_BURST  = 4
) (
  input logic           clk,
  input logic           reset_n,
  sram_arbiter_if.slave bus
);
  logic                  gnt, g0, g1, we, rd_tag_valid, r0, r1;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  port_e                 gnt_port, rd_tag_port;
  rr_burst_sel #(.MAX_BURST(MAX_BURST)) u_sel (
    .clk      (clk),
    .reset_n  (reset_n),
    .valid0   (bus.req0_valid),
    .valid1   (bus.req1_valid),
    .gnt      (gnt),
    .gnt_port (gnt_port)
  );
  always_comb begin
    g0 = gnt && gnt_port == PORT0;
    g1 = gnt && gnt_port == PORT1;
    we = g1 ? bus.req1_we : (g0 && bus.req0_we);
    addr = g1 ? bus.req1_addr : g0 ? bus.req0_addr : '0;
    wdata = g1 ? bus.req1_wdata : g0 ? bus.req0_wdata : '0;
    r0 = rd_tag_valid && rd_tag_port == PORT0;
    r1 = rd_tag_valid && rd_tag_port == PORT1;
  end
  assign bus.req0_ready = g0;
  assign bus.req1_ready = g1;
  assign bus.sram_en    = gnt;
  assign bus.sram_we    = we;
  assign bus.sram_addr  = addr;
  assign bus.sram_wdata = wdata;
  assign bus.rsp0_valid = r0;
  assign bus.rsp1_valid = r1;
  assign bus.rsp0_rdata = r0 ? bus.sram_rdata : '0;
  assign bus.rsp1_rdata = r1 ? bus.sram_rdata : '0;
  // Tag the read so its registered SRAM output is routed back one cycle later.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      rd_tag_valid <= 1'b0;
      rd_tag_port <= PORT0;
    end else begin
      rd_tag_valid <= gnt && !we;
      rd_tag_port <= gnt_port;
    end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: randomized scenarios against a per-cycle reference model of the arbiter.
module tb_sram_arbiter;
  localparam int MB = 4;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] mem [2048];
  logic [7:0] ref_mem [2048];
  logic [7:0] exp_d [4];
  sram_arbiter_if bus ();
  sram_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(11), .MAX_BURST(MB)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );
  always #5 clk = ~clk;
  // Behavioural SRAM: registered read, write data echoed on the output.
  always @(posedge clk)
    if (bus.sram_en) begin
      if (bus.sram_we) begin
        mem[bus.sram_addr] <= bus.sram_wdata;
        bus.sram_rdata <= bus.sram_wdata;
      end else bus.sram_rdata <= mem[bus.sram_addr];
    end
  // Reference model: grant rules applied to the current inputs, one pending read tracked.
  int          m_last = 1, m_run = MB, m_g, m_tport;
  logic        m_tv = 1'b0, m_we;
  logic [10:0] m_a;
  logic [7:0]  m_wd, m_td, m_r0d, m_r1d;
  always @(negedge clk) begin
    if (!reset_n) begin
      checks++;
      if ({bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid, bus.sram_en, bus.sram_we} !== 6'b0 ||
          bus.sram_addr !== 11'h0 || bus.sram_wdata !== 8'h0 || bus.rsp0_rdata !== 8'h0 || bus.rsp1_rdata !== 8'h0) begin
        errors++;
        $display("FAIL reset_outputs: rdy=%b%b rsp=%b%b en=%b we=%b addr=%h wd=%h, required all zero",
                 bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid, bus.sram_en, bus.sram_we,
                 bus.sram_addr, bus.sram_wdata);
      end
      m_last = 1; m_run = MB; m_tv = 1'b0;
    end else begin
      if (bus.req0_valid && bus.req1_valid) m_g = (m_run < MB) ? m_last : 1 - m_last;
      else m_g = bus.req0_valid ? 0 : bus.req1_valid ? 1 : -1;
      m_we = (m_g == 0) ? bus.req0_we : (m_g == 1) ? bus.req1_we : 1'b0;
      m_a  = (m_g == 0) ? bus.req0_addr : (m_g == 1) ? bus.req1_addr : 11'h0;
      m_wd = (m_g == 0) ? bus.req0_wdata : (m_g == 1) ? bus.req1_wdata : 8'h0;
      checks++;
      if (bus.req0_ready !== (m_g == 0) || bus.req1_ready !== (m_g == 1)) begin
        errors++;
        $display("FAIL grant: ready0/1=%b%b, required %b%b", bus.req0_ready, bus.req1_ready, m_g == 0, m_g == 1);
      end
      checks++;
      if ({bus.sram_en, bus.sram_we, bus.sram_addr, bus.sram_wdata} !== {m_g >= 0, m_we, m_a, m_wd}) begin
        errors++;
        $display("FAIL sram_bus: en=%b we=%b addr=%h wd=%h, required en=%b we=%b addr=%h wd=%h",
                 bus.sram_en, bus.sram_we, bus.sram_addr, bus.sram_wdata, m_g >= 0, m_we, m_a, m_wd);
      end
      m_r0d = (m_tv && m_tport == 0) ? m_td : 8'h0;
      m_r1d = (m_tv && m_tport == 1) ? m_td : 8'h0;
      checks++;
      if (bus.rsp0_valid !== (m_tv && m_tport == 0) || bus.rsp0_rdata !== m_r0d) begin
        errors++;
        $display("FAIL rsp0: valid=%b data=%h, required valid=%b data=%h",
                 bus.rsp0_valid, bus.rsp0_rdata, m_tv && m_tport == 0, m_r0d);
      end
      checks++;
      if (bus.rsp1_valid !== (m_tv && m_tport == 1) || bus.rsp1_rdata !== m_r1d) begin
        errors++;
        $display("FAIL rsp1: valid=%b data=%h, required valid=%b data=%h",
                 bus.rsp1_valid, bus.rsp1_rdata, m_tv && m_tport == 1, m_r1d);
      end
      if (m_g >= 0) begin
        if (m_we) ref_mem[m_a] = m_wd;
        m_tv = !m_we; m_tport = m_g; m_td = ref_mem[m_a];
        if (m_g == m_last) m_run = (m_run < MB) ? m_run + 1 : MB;
        else begin
          m_last = m_g; m_run = 1;
        end
      end else m_tv = 1'b0;
    end
  end
  task automatic next();
    @(posedge clk);
    #1;
  endtask
  task automatic set0(input logic v, input logic we, input logic [10:0] a, input logic [7:0] d);
    bus.req0_valid = v; bus.req0_we = we; bus.req0_addr = a; bus.req0_wdata = d;
  endtask
  task automatic set1(input logic v, input logic we, input logic [10:0] a, input logic [7:0] d);
    bus.req1_valid = v; bus.req1_we = we; bus.req1_addr = a; bus.req1_wdata = d;
  endtask
  task automatic idle();
    set0(1'b0, 1'b0, 11'h0, 8'h0);
    set1(1'b0, 1'b0, 11'h0, 8'h0);
  endtask
  task automatic do_reset();
    idle();
    reset_n = 1'b0;
    @(negedge clk);
    next();
    reset_n = 1'b1;
  endtask
  task automatic test_reset();
    idle();
    next();
    next();
    reset_n = 1'b1;
    set0(1'b1, 1'b0, 11'($urandom_range(0, 2047)), 8'h0);
    set1(1'b1, 1'b0, 11'($urandom_range(0, 2047)), 8'h0);
    repeat (3) next();
    reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.req0_ready, bus.req1_ready, bus.sram_en, bus.rsp0_valid, bus.rsp1_valid} !== 5'b0) begin
      errors++;
      $display("FAIL async_reset: rdy=%b%b en=%b rsp=%b%b, required 00000",
               bus.req0_ready, bus.req1_ready, bus.sram_en, bus.rsp0_valid, bus.rsp1_valid);
    end
    @(negedge clk);
    next();
    reset_n = 1'b1;
    #1;
    checks++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      errors++;
      $display("FAIL first_after_reset: rdy0/1=%b%b, required 10", bus.req0_ready, bus.req1_ready);
    end
    next();
    idle();
    next();
  endtask
  task automatic test_single_reads();
    for (int i = 0; i < 5; i++) begin
      set0(i < 4, 1'b0, 11'(i), 8'h0);
      @(negedge clk);
      checks++;
      if (bus.req0_ready !== (i < 4) || bus.rsp0_valid !== (i > 0) || bus.rsp1_valid !== 1'b0) begin
        errors++;
        $display("FAIL single_read[%0d]: ready0=%b rsp0=%b rsp1=%b, required %b %b 0",
                 i, bus.req0_ready, bus.rsp0_valid, bus.rsp1_valid, i < 4, i > 0);
      end
      if (i > 0) begin
        checks++;
        if (bus.rsp0_rdata !== exp_d[i-1]) begin
          errors++;
          $display("FAIL single_data[%0d]: got %h, required %h", i - 1, bus.rsp0_rdata, exp_d[i-1]);
        end
      end
      next();
    end
    @(negedge clk);
    checks++;
    if (bus.rsp0_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_tail: rsp0_valid=%b, required 0", bus.rsp0_valid);
    end
    next();
  endtask
  task automatic test_contended();
    int obs, ex;
    do_reset();
    set0(1'b1, 1'b0, 11'($urandom_range(0, 2047)), 8'h0);
    set1(1'b1, 1'b0, 11'($urandom_range(0, 2047)), 8'h0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      obs = bus.req1_ready ? 1 : bus.req0_ready ? 0 : -1;
      ex = (i / MB) % 2;
      checks++;
      if (obs != ex) begin
        errors++;
        $display("FAIL contend_grant[%0d]: port %0d, required %0d", i, obs, ex);
      end
      if (i > 0) begin
        checks++;
        if (bus.rsp0_valid !== (((i - 1) / MB) % 2 == 0) || bus.rsp1_valid !== (((i - 1) / MB) % 2 == 1)) begin
          errors++;
          $display("FAIL contend_rsp[%0d]: rsp0/1=%b%b, required port %0d", i, bus.rsp0_valid, bus.rsp1_valid, ((i - 1) / MB) % 2);
        end
      end
      next();
      if (obs == 0) bus.req0_addr = 11'($urandom_range(0, 2047));
      if (obs == 1) bus.req1_addr = 11'($urandom_range(0, 2047));
    end
    idle();
    next();
  endtask
  task automatic test_write_readback();
    set1(1'b1, 1'b1, 11'h3FF, 8'hA5);
    @(negedge clk);
    checks++;
    if ({bus.req1_ready, bus.sram_we, bus.sram_addr, bus.sram_wdata} !== {1'b1, 1'b1, 11'h3FF, 8'hA5}) begin
      errors++;
      $display("FAIL write: ready1=%b we=%b addr=%h wd=%h, required 1 1 3ff a5",
               bus.req1_ready, bus.sram_we, bus.sram_addr, bus.sram_wdata);
    end
    next();
    idle();
    set0(1'b1, 1'b0, 11'h3FF, 8'h0);
    @(negedge clk);
    checks++;
    if (bus.rsp1_valid !== 1'b0 || bus.req0_ready !== 1'b1) begin
      errors++;
      $display("FAIL write_norsp: rsp1_valid=%b ready0=%b, required 0 1", bus.rsp1_valid, bus.req0_ready);
    end
    next();
    idle();
    @(negedge clk);
    checks++;
    if (bus.rsp0_valid !== 1'b1 || bus.rsp0_rdata !== 8'hA5) begin
      errors++;
      $display("FAIL readback: rsp0_valid=%b data=%h, required 1 a5", bus.rsp0_valid, bus.rsp0_rdata);
    end
    next();
  endtask
  task automatic test_handover();
    do_reset();
    set0(1'b1, 1'b0, 11'($urandom_range(0, 2047)), 8'h0);
    @(negedge clk);
    checks++;
    if (bus.req0_ready !== 1'b1) begin
      errors++;
      $display("FAIL handover_solo: ready0=%b, required 1", bus.req0_ready);
    end
    next();
    set1(1'b1, 1'b0, 11'($urandom_range(0, 2047)), 8'h0);
    @(negedge clk);
    checks++;
    if (bus.req0_ready !== 1'b1) begin
      errors++;
      $display("FAIL handover_burst: ready0=%b, required 1", bus.req0_ready);
    end
    next();
    bus.req0_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.req1_ready !== 1'b1) begin
      errors++;
      $display("FAIL handover_drop: ready1=%b, required 1", bus.req1_ready);
    end
    next();
    bus.req0_valid = 1'b1;
    for (int j = 0; j < MB; j++) begin
      @(negedge clk);
      checks++;
      if (bus.req1_ready !== (j < MB - 1) || bus.req0_ready !== (j == MB - 1)) begin
        errors++;
        $display("FAIL handover_run[%0d]: rdy0/1=%b%b, required port %0d", j, bus.req0_ready, bus.req1_ready, j == MB - 1 ? 0 : 1);
      end
      next();
    end
    idle();
    next();
  endtask
  task automatic test_hold_stall();
    int wait_c;
    bit got;
    set0(1'b1, 1'b0, 11'($urandom_range(0, 2047)), 8'h0);
    for (int k = 0; k < 3; k++) begin
      repeat ($urandom_range(0, 3)) begin
        next();
        bus.req0_addr = 11'($urandom_range(0, 2047));
      end
      set1(1'b1, 1'b0, 11'h010, 8'h0);
      wait_c = 0;
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
        @(negedge clk);
        if (bus.req1_ready) begin
          got = 1'b1;
          checks++;
          if (bus.sram_addr !== 11'h010) begin
            errors++;
            $display("FAIL stall_addr: addr=%h, required 010", bus.sram_addr);
          end
        end else wait_c++;
        next();
        bus.req0_addr = 11'($urandom_range(0, 2047));
      end
      checks++;
      if (!got || wait_c > MB) begin
        errors++;
        $display("FAIL stall_wait: granted=%b after %0d cycles, required grant within %0d", got, wait_c, MB);
      end
      bus.req1_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.req1_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_single: ready1=%b, required 0", bus.req1_ready);
      end
    end
    next();
    idle();
    next();
  endtask
  task automatic test_random();
    bit r0 = 1'b0, r1 = 1'b0;
    int w0 = 0, w1 = 0;
    for (int i = 0; i < 400; i++) begin
      if (!bus.req0_valid || r0)
        set0($urandom_range(0, 9) < 7, $urandom_range(0, 2) == 0,
             ($urandom_range(0, 7) == 0) ? 11'h7FF : 11'($urandom_range(0, 15)), 8'($urandom));
      if (!bus.req1_valid || r1)
        set1($urandom_range(0, 9) < 7, $urandom_range(0, 2) == 0,
             ($urandom_range(0, 7) == 0) ? 11'h7FF : 11'($urandom_range(0, 15)), 8'($urandom));
      @(negedge clk);
      r0 = bus.req0_ready;
      r1 = bus.req1_ready;
      w0 = (bus.req0_valid && !r0) ? w0 + 1 : 0;
      w1 = (bus.req1_valid && !r1) ? w1 + 1 : 0;
      checks++;
      if (w0 > MB || w1 > MB) begin
        errors++;
        $display("FAIL random_wait[%0d]: waits %0d/%0d, required at most %0d", i, w0, w1, MB);
      end
      next();
    end
    idle();
    next();
    next();
  endtask
  initial begin
    for (int i = 0; i < 2048; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33; exp_d[3] = 8'h44;
    for (int i = 0; i < 4; i++) begin
      mem[i] = exp_d[i];
      ref_mem[i] = exp_d[i];
    end
    bus.sram_rdata = 8'h0;
    idle();
    test_reset();
    test_single_reads();
    test_contended();
    test_write_readback();
    test_handover();
    test_hold_stall();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, required completion before 200000 time units");
    $fatal(1);
  end
endmodule
